// File: rtl/shift_result_stage.sv
// shift_result_stage: registered output stage behind the 16-bit shifter.
// Captures result + flags (zero, neg, carry, illegal) into a small in-order
// queue with valid/ready on both sides.
// Optional macro SHIFT_STATS_EN adds op_count / illegal_count outputs.
module shift_result_stage #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         shift_result,
  input  logic [WIDTH-1:0]         in0,
  input  logic [3:0]               in1,
  input  logic [2:0]               shift_type,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic                     out_zero,
  output logic                     out_neg,
  output logic                     out_carry,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
`ifdef SHIFT_STATS_EN
  ,
  output logic [15:0]              op_count,
  output logic [15:0]              illegal_count
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             illegal;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        new_entry;
  entry_t        head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  logic [4:0]    left_idx;
  logic [3:0]    right_idx;
  logic          carry;
  logic          illegal;

  // No pass-through: readiness depends only on registered occupancy.
  assign in_ready  = !rst && (count < FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Flag generation for the incoming entry; illegal ops store a zero result.
  always_comb begin
    left_idx  = 5'd16 - {1'b0, in1};
    right_idx = in1 - 4'd1;
    carry     = 1'b0;
    illegal   = (shift_type[2:1] == 2'b11);
    if (in1 != 4'd0) begin
      case (shift_type)
        3'b000, 3'b010: carry = in0[left_idx[3:0]];
        3'b001, 3'b011: carry = in0[right_idx];
        3'b100:         carry = shift_result[0];
        3'b101:         carry = shift_result[WIDTH-1];
        default:        carry = 1'b0;
      endcase
    end
    new_entry.result  = illegal ? '0 : shift_result;
    new_entry.zero    = (new_entry.result == '0);
    new_entry.neg     = new_entry.result[WIDTH-1];
    new_entry.carry   = carry;
    new_entry.illegal = illegal;
  end

  // Queue storage, pointers and occupancy; reset discards held entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head fields come straight from storage; forced to zero when empty.
  always_comb begin
    head        = out_valid ? mem[rd_ptr] : '0;
    out_result  = head.result;
    out_zero    = head.zero;
    out_neg     = head.neg;
    out_carry   = head.carry;
    out_illegal = head.illegal;
  end

`ifdef SHIFT_STATS_EN
  // Push statistics: op_count wraps, illegal_count saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count      <= '0;
      illegal_count <= '0;
    end else if (push) begin
      op_count <= op_count + 16'd1;
      if (new_entry.illegal && illegal_count != 16'hFFFF)
        illegal_count <= illegal_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_result_stage.sv
// Self-checking bench for shift_result_stage: vector table of single-entry
// pushes plus hand sequences for fill/backpressure, reset and streaming.
module tb_shift_result_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] shift_result;
  logic [15:0] in0;
  logic [3:0]  in1;
  logic [2:0]  shift_type;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_zero, out_neg, out_carry, out_illegal;
  logic [1:0]  count;
`ifdef SHIFT_STATS_EN
  logic [15:0] op_count, illegal_count;
`endif

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  shift_result_stage #(.WIDTH(16), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .shift_result(shift_result), .in0(in0), .in1(in1), .shift_type(shift_type),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_neg(out_neg), .out_carry(out_carry),
    .out_illegal(out_illegal), .count(count)
`ifdef SHIFT_STATS_EN
    , .op_count(op_count), .illegal_count(illegal_count)
`endif
  );

  typedef struct {
    logic [15:0] in0;
    logic [3:0]  in1;
    logic [2:0]  typ;
    logic [15:0] sr;
    logic [15:0] res;
    logic        z, n, c, il;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [3:0] b,
                       input logic [2:0] t, input logic [15:0] r);
    in0 = a; in1 = b; shift_type = t; shift_result = r;
  endtask

  task automatic chk_head(input string name, input logic [15:0] res,
                          input logic z, input logic n, input logic c, input logic il);
    chk({name, ".valid"},   32'(out_valid),   32'd1);
    chk({name, ".result"},  32'(out_result),  32'(res));
    chk({name, ".zero"},    32'(out_zero),    32'(z));
    chk({name, ".neg"},     32'(out_neg),     32'(n));
    chk({name, ".carry"},   32'(out_carry),   32'(c));
    chk({name, ".illegal"}, 32'(out_illegal), 32'(il));
  endtask

  vec_t vecs [13];
  int   n_illegal;

  initial begin
    vecs[0]  = '{16'h8001, 4'd1,  3'b000, 16'h0002, 16'h0002, 0, 0, 1, 0};
    vecs[1]  = '{16'h8000, 4'd4,  3'b011, 16'hF800, 16'hF800, 0, 1, 0, 0};
    vecs[2]  = '{16'h8001, 4'd1,  3'b100, 16'h0003, 16'h0003, 0, 0, 1, 0};
    vecs[3]  = '{16'h0001, 4'd0,  3'b001, 16'h0001, 16'h0001, 0, 0, 0, 0};
    vecs[4]  = '{16'h1234, 4'd3,  3'b110, 16'h1234, 16'h0000, 1, 0, 0, 1};
    vecs[5]  = '{16'h0003, 4'd1,  3'b001, 16'h0001, 16'h0001, 0, 0, 1, 0};
    vecs[6]  = '{16'h4000, 4'd2,  3'b010, 16'h0000, 16'h0000, 1, 0, 1, 0};
    vecs[7]  = '{16'h0001, 4'd15, 3'b000, 16'h8000, 16'h8000, 0, 1, 0, 0};
    vecs[8]  = '{16'h0002, 4'd15, 3'b000, 16'h0000, 16'h0000, 1, 0, 1, 0};
    vecs[9]  = '{16'h0001, 4'd1,  3'b101, 16'h8000, 16'h8000, 0, 1, 1, 0};
    vecs[10] = '{16'hFFFF, 4'd5,  3'b111, 16'hFFFF, 16'h0000, 1, 0, 0, 1};
    vecs[11] = '{16'h8000, 4'd15, 3'b011, 16'hFFFF, 16'hFFFF, 0, 1, 0, 0};
    vecs[12] = '{16'h4000, 4'd15, 3'b001, 16'h0000, 16'h0000, 1, 0, 1, 0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(16'h0, 4'd0, 3'b000, 16'h0);
    step(); step();
    // reset state
    chk("rst.count",     32'(count),      32'd0);
    chk("rst.out_valid", 32'(out_valid),  32'd0);
    chk("rst.in_ready",  32'(in_ready),   32'd0);
    chk("rst.result",    32'(out_result), 32'd0);
    chk("rst.flags",     32'({out_zero, out_neg, out_carry, out_illegal}), 32'd0);
`ifdef SHIFT_STATS_EN
    chk("rst.op_count",  32'(op_count),      32'd0);
    chk("rst.ill_count", 32'(illegal_count), 32'd0);
`endif
    rst = 1'b0;
    #1;
    chk("post_rst.in_ready", 32'(in_ready), 32'd1);

    // table: push into empty queue, head visible one cycle later, then pop
    n_illegal = 0;
    foreach (vecs[i]) begin
      drive(vecs[i].in0, vecs[i].in1, vecs[i].typ, vecs[i].sr);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk_head($sformatf("vec%0d", i), vecs[i].res, vecs[i].z, vecs[i].n, vecs[i].c, vecs[i].il);
      chk($sformatf("vec%0d.count", i), 32'(count), 32'd1);
      if (vecs[i].il) n_illegal++;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk($sformatf("vec%0d.drained", i), 32'(out_valid), 32'd0);
    end
`ifdef SHIFT_STATS_EN
    chk("tbl.op_count",  32'(op_count),      32'd13);
    chk("tbl.ill_count", 32'(illegal_count), 32'(n_illegal));
`endif

    // fill to DEPTH under backpressure; head holds
    drive(16'h8000, 4'd4, 3'b011, 16'hF800); in_valid = 1'b1; step();
    drive(16'h8001, 4'd1, 3'b100, 16'h0003); step();
    drive(16'hAAAA, 4'd1, 3'b000, 16'h5554); step();
    chk("full.count",    32'(count),    32'd2);
    chk("full.in_ready", 32'(in_ready), 32'd0);
    chk_head("full.head", 16'hF800, 0, 1, 0, 0);
    // full with pop: one pop, no push this cycle
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("afterpop.count",    32'(count),    32'd1);
    chk("afterpop.in_ready", 32'(in_ready), 32'd1);
    chk_head("second", 16'h0003, 0, 0, 1, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("drain.valid", 32'(out_valid), 32'd0);
    chk("drain.count", 32'(count),     32'd0);

    // reset with an entry held: entry discarded, nothing accepted on reset edge
    drive(16'h0001, 4'd0, 3'b001, 16'h0001); in_valid = 1'b1; step();
    chk_head("held", 16'h0001, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    chk("midrst.count", 32'(count),     32'd0);
    chk("midrst.valid", 32'(out_valid), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    step();
    chk("postrst.count", 32'(count),     32'd0);
    chk("postrst.valid", 32'(out_valid), 32'd0);

    // streaming: steady count=1 with push+pop every cycle, pointer wraps
    drive(16'h0100, 4'd0, 3'b000, 16'h0100); in_valid = 1'b1; step();
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      drive(16'h0100 + 16'(k), 4'd0, 3'b000, 16'h0100 + 16'(k));
      step();
      chk($sformatf("stream%0d.count", k), 32'(count), 32'd1);
      chk($sformatf("stream%0d.head", k),  32'(out_result), 32'h0100 + 32'(k));
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    chk("stream.end", 32'(count), 32'd0);
`ifdef SHIFT_STATS_EN
    chk("stream.op_count",  32'(op_count),      32'd9);
    chk("stream.ill_count", 32'(illegal_count), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/shift_result_stage.md
Name: shift_result_stage

Overview:
Registered output stage directly downstream of the 16-bit shifting unit. Captures the shifter's combinational result together with the operands and shift type that produced it. Generates zero, negative, carry and illegal-op flags, and buffers results in a small in-order queue with valid/ready handshakes on both sides. Feeds the ALU writeback/flag logic.

Parameters:
WIDTH, 16, data width; must match the shifter (only 16 is supported).
DEPTH, 2, queue entries; power of two, at least 2.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream result/operands valid this cycle
in_ready  output  1  stage can accept an entry this cycle
shift_result  input  16  combinational result from the shifting unit
in0  input  16  operand that was shifted
in1  input  4  shift amount 0..15
shift_type  input  3  000 lsl, 001 lsr, 010 asl, 011 asr, 100 rol, 101 ror, 110/111 unused
out_valid  output  1  head entry valid
out_ready  input  1  downstream accepts head entry
out_result  output  16  head entry result
out_zero  output  1  head result == 0
out_neg  output  1  head result bit 15
out_carry  output  1  last bit shifted/rotated out
out_illegal  output  1  head entry came from shift_type 110/111
count  output  clog2(DEPTH)+1  entries currently held

Behaviour:
- Reset (sync, rst=1 at a clk edge): count=0, out_valid=0, out_result=0, all flags 0, and in_ready=0 during the reset cycle. Entries held before a mid-operation reset are discarded, and nothing is accepted on the reset edge.
- in_ready = !rst && (count < DEPTH). No pass-through when full: if count==DEPTH and the head is popped, in_ready rises the next cycle.
- Push occurs when in_valid && in_ready at the edge. Pop occurs when out_valid && out_ready at the edge. A simultaneous push and pop keeps count unchanged and preserves order.
- Strict FIFO order. Latency from an accepted push into an empty queue to out_valid=1 is 1 cycle.
- Head outputs are driven from registered queue storage. They hold stable while out_valid && !out_ready.
- Flags are computed at push time from the inputs and stored with the entry:
  - zero = (shift_result == 16'h0000).
  - neg = shift_result[15].
  - carry:
    - in1==0: always 0.
    - 000/010: in0[16-in1].
    - 001/011: in0[in1-1].
    - 100: shift_result[0].
    - 101: shift_result[15].
    - 110/111: 0.
  - illegal = (shift_type[2:1]==2'b11). For illegal entries the stored result is forced to 0, so zero=1 and neg=0, regardless of the shift_result input.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count saturates by construction (never exceeds DEPTH, never underflows).
- out_valid = (count != 0).

Optional Feature:
Macro SHIFT_STATS_EN.
- Defined:
  - Adds output op_count (16) and output illegal_count (16), both reset to 0.
  - op_count increments on every push and wraps 16'hFFFF to 0.
  - illegal_count increments on every push with illegal=1 and saturates at 16'hFFFF.
  - Both are cleared by rst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset, then push {in0=16'h8001, in1=1, type=000, shift_result=16'h0002} -> next cycle out_valid=1, out_result=16'h0002, carry=1, zero=0, neg=0, illegal=0.
2. Push {in0=16'h8000, in1=4, type=011, shift_result=16'hF800} then {in0=16'h8001, in1=1, type=100, shift_result=16'h0003} with out_ready=0.
   - count=2, in_ready=0, head holds 16'hF800 with neg=1, carry=0.
   - Raise out_ready: results emerge in order; the second has carry=1.
3. Full queue (count=2) with in_valid=1 and out_ready=1 for one cycle -> one pop and no push that cycle; in_ready=1 the next cycle; count=1.
4. Push type=110 with shift_result=16'h1234 -> out_result=0, zero=1, illegal=1, carry=0. With SHIFT_STATS_EN: illegal_count=1, op_count=1.
5. Push {in0=16'h0001, in1=0, type=001, shift_result=16'h0001} -> carry=0, zero=0. Then assert rst with 1 entry held -> count=0 and out_valid=0 the next cycle; the held entry is never seen.
6. Stream 8 pushes, each with simultaneous pop from count=1 steady state -> count stays 1, order preserved, pointer wrap exercised. With SHIFT_STATS_EN: op_count=9.
